run_ctrl: RTL and testbench
===========================

# run_ctrl

Parametrised run controller for RISC-V core simulation and FPGA bring-up. It sits beside `top` and sequences the core's reset release. It then watches the memory-stage write port for a store to the tohost address and classifies the run as pass, fail, timeout or hang. It replaces fixed-delay reset and stop timers with a synthesizable, cycle-accurate FSM that can also freeze the core when the run ends.

## Interface
Parameters:
- XLEN, 32, data/address/PC width
- RESET_CYCLES, 2, cycles core_reset stays high after `reset` deasserts (≥1)
- MAX_CYCLES, 30, RUN-state cycle budget before timeout (≥1)
- STALL_LIMIT, 8, consecutive RUN cycles with unchanged PC that flag a hang (0 disables)
- TOHOST_ADDR, 32'd100, store address that ends the run
- PASS_VALUE, 32'd25, store data meaning pass
- HALT_ON_DONE, 1, 1 re-asserts core_reset in terminal states

Ports:
- Clock/reset: one clock; reset is synchronous and active-high. Ports are `clk` and `reset`.
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- memwritem  in  1  core memory-stage store enable
- dataadrm  in  XLEN  store address
- writedatam  in  XLEN  store data
- pc  in  XLEN  fetch PC
- core_reset  out  1  reset to core
- done  out  1  run finished (terminal state)
- pass  out  1  terminal state is PASS
- status  out  3  0 HOLD, 1 RUN, 2 PASS, 3 FAIL, 4 TIMEOUT, 5 HANG
- cycle_count  out  CNT_W = $clog2(MAX_CYCLES+1)  RUN cycles elapsed
- result_data  out  XLEN  data of the terminating tohost store

## Operation
- States: HOLD, RUN, then the terminal states PASS, FAIL, TIMEOUT, HANG.
- Reset: state=HOLD, hold_cnt=0, cycle_count=0, stall_cnt=0, result_data=0, core_reset=1, done=0, pass=0, status=0.
- HOLD: each edge with reset=0 increments hold_cnt. When hold_cnt==RESET_CYCLES-1 the next state is RUN. core_reset=1 throughout HOLD.
- RUN: core_reset=0 and status=1. cycle_count increments every RUN cycle and saturates at MAX_CYCLES. pc_q registers pc.
- Stall counter: stall_cnt increments when pc==pc_q and clears otherwise. pc_q is valid only after the first RUN cycle; stall_cnt=0 on that cycle.
- Exit conditions evaluated in RUN, priority highest first:
  1. memwritem && dataadrm==TOHOST_ADDR: go to PASS if writedatam==PASS_VALUE, else FAIL. result_data captures writedatam.
  2. STALL_LIMIT!=0 && stall_cnt==STALL_LIMIT-1 && pc==pc_q: go to HANG.
  3. cycle_count==MAX_CYCLES-1: go to TIMEOUT.
- Stores to any other address are ignored.
- Terminal states are sticky until reset.
  - done=1 in every terminal state; pass=1 only in PASS.
  - core_reset=HALT_ON_DONE.
  - cycle_count, result_data and status freeze.
  - Further stores are ignored.
- Outputs are registered state decodes; there is no combinational path from inputs to outputs.

## Timing
- With reset deasserted after edge E0, core_reset falls after edge E0+RESET_CYCLES. The core sees exactly RESET_CYCLES low-reset edges with core_reset high.
- A terminating store sampled at edge N gives done/status/result_data valid after edge N (1-cycle latency). With HALT_ON_DONE=1, core_reset also rises then.
- Timeout: if RUN is entered at edge R and no exit occurs, TIMEOUT is entered at edge R+MAX_CYCLES. cycle_count then reads MAX_CYCLES.
- Simultaneous events:
  - tohost store on the timeout cycle: PASS/FAIL wins.
  - Store on the hang cycle: the store wins.
- reset asserted in any state, including mid-RUN or terminal: the next edge returns to HOLD with all reset values, and core_reset stays 1.
- A store while in HOLD is ignored.

## Test plan
- Default params; reset high 2 cycles then low; store addr 100, data 25 at the 10th RUN cycle -> core_reset low after 2 edges, status=2, pass=1, done=1, result_data=25, cycle_count=10, core_reset=1 one cycle after the store.
- Store addr 100, data 7 -> status=3, pass=0, done=1, result_data=7. A following store of 25 leaves the state unchanged.
- No tohost store, PC advancing by 4 each cycle -> status=4 exactly 30 cycles after RUN entry, cycle_count=30. A store to addr 96 is ignored.
- PC held at 0x40 from RUN cycle 5 -> status=5 after 8 equal-PC cycles. STALL_LIMIT=0 variant: no HANG, reaches TIMEOUT.
- Store addr 100/data 25 on the MAX_CYCLES-th cycle -> PASS, not TIMEOUT. The same store on the hang cycle -> PASS.
- reset pulsed mid-RUN at cycle 12, and again in PASS -> next edge status=0, core_reset=1, cycle_count=0, result_data=0. The run then restarts normally. HALT_ON_DONE=0 variant keeps core_reset=0 in PASS.

Source files
------------

// File: rtl/run_ctrl.sv
`timescale 1ns/1ps
// Run controller: releases core reset after RESET_CYCLES, then classifies the run as PASS/FAIL/TIMEOUT/HANG.
// All outputs are registered; a terminating event shows up one cycle after it is sampled; no backpressure.
module run_ctrl #(
   parameter int              XLEN         = 32,
   parameter int              RESET_CYCLES = 2,
   parameter int              MAX_CYCLES   = 30,
   parameter int              STALL_LIMIT  = 8,
   parameter logic [XLEN-1:0] TOHOST_ADDR  = 32'd100,
   parameter logic [XLEN-1:0] PASS_VALUE   = 32'd25,
   parameter bit              HALT_ON_DONE = 1'b1,
   localparam int             CNT_W        = $clog2(MAX_CYCLES + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             memwritem,
   input  logic [XLEN-1:0]  dataadrm,
   input  logic [XLEN-1:0]  writedatam,
   input  logic [XLEN-1:0]  pc,
   output logic             core_reset,
   output logic             done,
   output logic             pass,
   output logic [2:0]       status,
   output logic [CNT_W-1:0] cycle_count,
   output logic [XLEN-1:0]  result_data
);

   localparam int HOLD_W  = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
   localparam int STALL_W = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT) : 1;

   localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0]   CNT_MAX    = CNT_W'(MAX_CYCLES);
   localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(MAX_CYCLES - 1);
   localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'((STALL_LIMIT > 0) ? STALL_LIMIT - 1 : 0);

   // Encoding doubles as the status code.
   typedef enum logic [2:0] {
      S_HOLD    = 3'd0,
      S_RUN     = 3'd1,
      S_PASS    = 3'd2,
      S_FAIL    = 3'd3,
      S_TIMEOUT = 3'd4,
      S_HANG    = 3'd5
   } state_e;

   state_e             state_q, state_d;
   logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
   logic [CNT_W-1:0]   cycle_cnt_q, cycle_cnt_d;
   logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [XLEN-1:0]    pc_q, pc_d;
   logic [XLEN-1:0]    result_q, result_d;
   logic               pc_same;
   logic               tohost;
   logic               done_w;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_HOLD;
         hold_cnt_q  <= '0;
         cycle_cnt_q <= '0;
         stall_cnt_q <= '0;
         pc_q        <= '0;
         result_q    <= '0;
      end else begin
         state_q     <= state_d;
         hold_cnt_q  <= hold_cnt_d;
         cycle_cnt_q <= cycle_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         pc_q        <= pc_d;
         result_q    <= result_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      hold_cnt_d  = hold_cnt_q;
      cycle_cnt_d = cycle_cnt_q;
      stall_cnt_d = stall_cnt_q;
      pc_d        = pc_q;
      result_d    = result_q;
      // pc_q holds a stale value during the first RUN cycle (cycle count still zero).
      pc_same     = (cycle_cnt_q != '0) && (pc == pc_q);
      tohost      = memwritem && (dataadrm == TOHOST_ADDR);

      case (state_q)
         S_HOLD: begin
            hold_cnt_d = hold_cnt_q + 1'b1;
            if (hold_cnt_q == HOLD_LAST) begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            pc_d = pc;
            if (cycle_cnt_q != CNT_MAX) begin
               cycle_cnt_d = cycle_cnt_q + 1'b1;
            end
            if (!pc_same) begin
               stall_cnt_d = '0;
            end else if (stall_cnt_q != '1) begin
               stall_cnt_d = stall_cnt_q + 1'b1;
            end
            if (tohost) begin
               result_d = writedatam;
               state_d  = (writedatam == PASS_VALUE) ? S_PASS : S_FAIL;
            end else if ((STALL_LIMIT != 0) && pc_same && (stall_cnt_q == STALL_LAST)) begin
               state_d = S_HANG;
            end else if (cycle_cnt_q == CNT_LAST) begin
               state_d = S_TIMEOUT;
            end
         end
         default: begin
            state_d = state_q;
         end
      endcase
   end

   assign done_w      = (state_q != S_HOLD) && (state_q != S_RUN);
   assign done        = done_w;
   assign pass        = (state_q == S_PASS);
   assign status      = state_q;
   assign core_reset  = (state_q == S_HOLD) || (done_w && HALT_ON_DONE);
   assign cycle_count = cycle_cnt_q;
   assign result_data = result_q;

endmodule

// File: tb/tb_run_ctrl.sv
`timescale 1ns/1ps
// Bench for run_ctrl: three instances (default, STALL_LIMIT=0, HALT_ON_DONE=0) share stimulus
// and are compared every cycle against a history-based model of the run rules.
module tb_run_ctrl;

   localparam int RC = 2;
   localparam int MC = 30;

   logic        clk;
   logic        reset;
   logic        memwritem;
   logic [31:0] dataadrm;
   logic [31:0] writedatam;
   logic [31:0] pc;

   logic        cr [3];
   logic        dn [3];
   logic        ps [3];
   logic [2:0]  st [3];
   logic [4:0]  cc [3];
   logic [31:0] rd [3];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   run_ctrl u0 (
      .clk(clk), .reset(reset), .memwritem(memwritem), .dataadrm(dataadrm),
      .writedatam(writedatam), .pc(pc), .core_reset(cr[0]), .done(dn[0]),
      .pass(ps[0]), .status(st[0]), .cycle_count(cc[0]), .result_data(rd[0])
   );

   run_ctrl #(.STALL_LIMIT(0)) u1 (
      .clk(clk), .reset(reset), .memwritem(memwritem), .dataadrm(dataadrm),
      .writedatam(writedatam), .pc(pc), .core_reset(cr[1]), .done(dn[1]),
      .pass(ps[1]), .status(st[1]), .cycle_count(cc[1]), .result_data(rd[1])
   );

   run_ctrl #(.HALT_ON_DONE(1'b0)) u2 (
      .clk(clk), .reset(reset), .memwritem(memwritem), .dataadrm(dataadrm),
      .writedatam(writedatam), .pc(pc), .core_reset(cr[2]), .done(dn[2]),
      .pass(ps[2]), .status(st[2]), .cycle_count(cc[2]), .result_data(rd[2])
   );

   // Model: low-reset edges since reset, PCs seen during the run, and per-instance verdicts.
   int          m_t;
   logic [31:0] pcs [$];
   bit          m_term [3];
   int          m_st   [3];
   int          m_cc   [3];
   logic [31:0] m_res  [3];
   bit          armed;
   int          rk;
   int          n_vec;
   int          n_err;

   function automatic int stall_lim(int i);
      return (i == 1) ? 0 : 8;
   endfunction

   function automatic bit halt(int i);
      return (i != 2);
   endfunction

   // Hang: the last L+1 run PCs are all identical.
   function automatic bit stalled(int L);
      int k;
      k = pcs.size();
      if (L == 0 || k < L + 1) return 1'b0;
      for (int j = 0; j < L; j++) begin
         if (pcs[k-1-j] != pcs[k-2-j]) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic model_edge();
      int k;
      if (reset) begin
         m_t = 0;
         pcs.delete();
         for (int i = 0; i < 3; i++) begin
            m_term[i] = 1'b0;
            m_st[i]   = 0;
            m_cc[i]   = 0;
            m_res[i]  = '0;
         end
      end else if (m_t < RC) begin
         m_t++;
      end else begin
         pcs.push_back(pc);
         k = pcs.size();
         for (int i = 0; i < 3; i++) begin
            if (!m_term[i]) begin
               m_cc[i] = (k > MC) ? MC : k;
               if (memwritem && dataadrm == 32'd100) begin
                  m_term[i] = 1'b1;
                  m_st[i]   = (writedatam == 32'd25) ? 2 : 3;
                  m_res[i]  = writedatam;
               end else if (stalled(stall_lim(i))) begin
                  m_term[i] = 1'b1;
                  m_st[i]   = 5;
               end else if (k == MC) begin
                  m_term[i] = 1'b1;
                  m_st[i]   = 4;
               end
            end
         end
      end
   endtask

   task automatic check_all();
      bit          hold;
      logic        e_cr, e_dn, e_ps;
      logic [2:0]  e_st;
      logic [4:0]  e_cc;
      logic [31:0] e_rd;
      hold = (m_t < RC);
      for (int i = 0; i < 3; i++) begin
         e_st = hold ? 3'd0 : (m_term[i] ? 3'(m_st[i]) : 3'd1);
         e_cr = hold || (m_term[i] && halt(i));
         e_dn = m_term[i];
         e_ps = m_term[i] && (m_st[i] == 2);
         e_cc = 5'(m_cc[i]);
         e_rd = m_res[i];
         n_vec++;
         if ({cr[i], dn[i], ps[i], st[i], cc[i], rd[i]} !== {e_cr, e_dn, e_ps, e_st, e_cc, e_rd}) begin
            n_err++;
            $display("FAIL cycle u%0d t=%0t: got cr=%0b done=%0b pass=%0b st=%0d cc=%0d rd=%0d, want cr=%0b done=%0b pass=%0b st=%0d cc=%0d rd=%0d",
                     i, $time, cr[i], dn[i], ps[i], st[i], cc[i], rd[i], e_cr, e_dn, e_ps, e_st, e_cc, e_rd);
         end
      end
   endtask

   task automatic lit(string name, logic [31:0] got, logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d", name, got, exp);
      end
   endtask

   task automatic cyc(bit rst, bit we, logic [31:0] a, logic [31:0] d, logic [31:0] p);
      reset      = rst;
      memwritem  = we;
      dataadrm   = a;
      writedatam = d;
      pc         = p;
      @(posedge clk);
      model_edge();
      armed = armed || rst;
      @(negedge clk);
      if (armed) check_all();
   endtask

   task automatic noise(bit rst, logic [31:0] p);
      cyc(rst, 1'($urandom_range(0, 1)), 32'd104 + 32'(4 * $urandom_range(0, 20)), $urandom, p);
   endtask

   task automatic do_reset(int n);
      rk = 0;
      for (int j = 0; j < n; j++) noise(1'b1, $urandom);
   endtask

   // Tohost passing stores during HOLD must be ignored.
   task automatic do_hold();
      for (int j = 0; j < RC; j++) cyc(1'b0, 1'b1, 32'd100, 32'd25, 32'h0);
   endtask

   task automatic do_run(int n, int store_at, logic [31:0] sa, logic [31:0] sd, int stall_from);
      logic [31:0] p;
      for (int j = 0; j < n; j++) begin
         rk++;
         p = (stall_from != 0 && rk >= stall_from) ? 32'h40 : 32'h100 + 32'(4 * rk);
         if (rk == store_at) cyc(1'b0, 1'b1, sa, sd, p);
         else                noise(1'b0, p);
      end
   endtask

   initial begin
      int n, sat, sf;
      logic [31:0] sa, sd;
      n_vec = 0;
      n_err = 0;
      armed = 1'b0;
      m_t   = 0;

      // Reset release timing and PASS at the 10th RUN cycle.
      do_reset(2);
      lit("reset_status", 32'(st[0]), 0);
      lit("reset_core_reset", 32'(cr[0]), 1);
      cyc(1'b0, 1'b1, 32'd100, 32'd25, 32'h0);
      lit("hold1_core_reset", 32'(cr[0]), 1);
      cyc(1'b0, 1'b1, 32'd100, 32'd25, 32'h0);
      lit("run_core_reset", 32'(cr[0]), 0);
      lit("run_status", 32'(st[0]), 1);
      do_run(12, 10, 32'd100, 32'd25, 0);
      lit("pass_status", 32'(st[0]), 2);
      lit("pass_flag", 32'(ps[0]), 1);
      lit("pass_result", rd[0], 25);
      lit("pass_cycles", 32'(cc[0]), 10);
      lit("pass_core_reset", 32'(cr[0]), 1);
      lit("nohalt_core_reset", 32'(cr[2]), 0);
      do_run(3, 13, 32'd100, 32'd7, 0);
      lit("pass_sticky_result", rd[0], 25);

      // Reset while in PASS, then a FAIL run.
      do_reset(1);
      lit("rst_pass_result", rd[0], 0);
      lit("rst_pass_cycles", 32'(cc[0]), 0);
      do_hold();
      do_run(10, 5, 32'd100, 32'd7, 0);
      lit("fail_status", 32'(st[0]), 3);
      lit("fail_result", rd[0], 7);
      do_run(2, 11, 32'd100, 32'd25, 0);
      lit("fail_sticky", 32'(st[0]), 3);

      // Timeout with an ignored store to 96.
      do_reset(2); do_hold();
      do_run(29, 8, 32'd96, 32'd25, 0);
      lit("pre_timeout_status", 32'(st[0]), 1);
      do_run(1, 0, 32'd0, 32'd0, 0);
      lit("timeout_status", 32'(st[0]), 4);
      lit("timeout_cycles", 32'(cc[0]), 30);
      do_run(3, 0, 32'd0, 32'd0, 0);

      // Hang from PC held at 0x40 from RUN cycle 5; STALL_LIMIT=0 instance times out.
      do_reset(2); do_hold();
      do_run(12, 0, 32'd0, 32'd0, 5);
      lit("pre_hang_status", 32'(st[0]), 1);
      do_run(1, 0, 32'd0, 32'd0, 5);
      lit("hang_status", 32'(st[0]), 5);
      lit("hang_cycles", 32'(cc[0]), 13);
      do_run(20, 0, 32'd0, 32'd0, 5);
      lit("nostall_timeout", 32'(st[1]), 4);

      // Store on the timeout cycle, then on the hang cycle.
      do_reset(2); do_hold();
      do_run(32, 30, 32'd100, 32'd25, 0);
      lit("store_on_timeout", 32'(st[0]), 2);
      lit("store_on_timeout_cc", 32'(cc[0]), 30);
      do_reset(2); do_hold();
      do_run(16, 13, 32'd100, 32'd25, 5);
      lit("store_on_hang", 32'(st[0]), 2);

      // Reset mid-RUN at cycle 12, then a normal restart.
      do_reset(2); do_hold();
      do_run(12, 0, 32'd0, 32'd0, 0);
      do_reset(1);
      lit("midrun_status", 32'(st[0]), 0);
      lit("midrun_core_reset", 32'(cr[0]), 1);
      lit("midrun_cycles", 32'(cc[0]), 0);
      do_hold();
      do_run(8, 6, 32'd100, 32'd25, 0);
      lit("restart_pass", 32'(st[0]), 2);

      // Randomized runs, occasionally cut short by a reset pulse.
      for (int it = 0; it < 40; it++) begin
         do_reset(1 + $urandom_range(0, 1));
         do_hold();
         n   = $urandom_range(5, 40);
         sat = $urandom_range(1, 35);
         case ($urandom_range(0, 2))
            0:       sa = 32'd100;
            1:       sa = 32'd96;
            default: sa = $urandom_range(0, 200);
         endcase
         sd = ($urandom_range(0, 1) == 1) ? 32'd25 : $urandom;
         sf = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 25);
         if ($urandom_range(0, 4) == 0) begin
            do_run(n / 2, sat, sa, sd, sf);
            do_reset(1);
            do_hold();
         end
         do_run(n, sat, sa, sd, sf);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
